// File: rtl/posit8_pkg.sv
// Shared widths, constants and pipeline record types for the 8-bit posit (es = 0) datapath.
// The pack stage records are kept here so the top and the rounding helper agree on layout.
package posit8_pkg;

  localparam int UPOSIT_W = 19;
  localparam int FRAC_W   = 13;
  localparam int EXP_W    = 5;
  localparam int STR_W    = FRAC_W + 8;

  localparam logic [EXP_W-1:0] EXP_BIAS = 5'd14;

  localparam logic [7:0] POSIT_ZERO   = 8'h00;
  localparam logic [7:0] POSIT_NAR    = 8'h80;
  localparam logic [7:0] POSIT_MAXPOS = 8'h7F;
  localparam logic [7:0] POSIT_MINPOS = 8'h01;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] frac;
  } uposit_t;

  // run_len is the length of the run of identical regime bits (before the terminator)
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              nar;
    logic              sat_hi;
    logic              sat_lo;
    logic              reg_pos;
    logic [2:0]        run_len;
    logic [FRAC_W-1:0] frac;
  } s1_t;

  typedef struct packed {
    logic       sign;
    logic       zero;
    logic       nar;
    logic [6:0] mag;
  } s2_t;

endpackage

// File: rtl/posit8_regime_round.sv
// Combinational middle stage: places regime and fraction into the 7-bit magnitude string,
// rounds to nearest even on the dropped bits, and clamps to minpos/maxpos.
module posit8_regime_round
  import posit8_pkg::*;
(
  input  logic              reg_pos,
  input  logic [2:0]        run_len,
  input  logic [FRAC_W-1:0] frac,
  input  logic              sat_hi,
  input  logic              sat_lo,
  output logic [6:0]        mag
);

  logic [STR_W-1:0] tail;
  logic [STR_W-1:0] fill;
  logic [STR_W-1:0] str;
  logic [6:0]       mag_raw;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic [7:0]       rounded;

  // The terminator rides at the top of the tail; a positive regime back-fills ones above it
  always_comb begin
    tail    = {~reg_pos, frac, {(STR_W-1-FRAC_W){1'b0}}};
    fill    = reg_pos ? ~({STR_W{1'b1}} >> run_len) : '0;
    str     = (tail >> run_len) | fill;
    mag_raw = str[STR_W-1 -: 7];
    guard   = str[STR_W-8];
    sticky  = |str[STR_W-9:0];
    inc     = guard & (sticky | mag_raw[0]);
    rounded = {1'b0, mag_raw} + {7'b0, inc};
    if (sat_hi || rounded[7]) begin
      mag = POSIT_MAXPOS[6:0];
    end else if (sat_lo || (rounded[6:0] == 7'd0)) begin
      mag = POSIT_MINPOS[6:0];
    end else begin
      mag = rounded[6:0];
    end
  end

endmodule

// File: rtl/posit_pack_8bit.sv
// Three-stage valid/ready pipeline packing an unpacked posit product into an 8-bit posit.
// S1 classifies the scale, S2 shifts/rounds/saturates, S3 applies sign and specials.
module posit_pack_8bit
  import posit8_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [UPOSIT_W-1:0] in_uposit,
  input  logic                in_zero,
  input  logic                in_nar,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_posit
);

  uposit_t    u;
  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  logic [7:0] out_d;
  logic [6:0] s2_mag;
  logic       v1, v2, v3;
  logic       s1_free, s2_free, s3_free;

  assign u = uposit_t'(in_uposit);

  // A stage may load when it is empty or its contents move on this same edge
  assign s3_free   = !v3 | out_ready;
  assign s2_free   = !v2 | s3_free;
  assign s1_free   = !v1 | s2_free;
  assign in_ready  = s1_free;
  assign out_valid = v3;

  // Scale k = exponent - bias; run length is k+1 for k >= 0 and -k otherwise
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = u.sign;
    s1_d.zero    = in_zero;
    s1_d.nar     = in_nar;
    s1_d.sat_hi  = u.exponent > (EXP_BIAS + 5'd6);
    s1_d.sat_lo  = u.exponent < (EXP_BIAS - 5'd6);
    s1_d.reg_pos = u.exponent >= EXP_BIAS;
    s1_d.run_len = s1_d.reg_pos ? 3'(u.exponent - (EXP_BIAS - 5'd1))
                                : 3'(EXP_BIAS - u.exponent);
    s1_d.frac    = u.frac;
  end

  posit8_regime_round u_regime_round (
    .reg_pos (s1_q.reg_pos),
    .run_len (s1_q.run_len),
    .frac    (s1_q.frac),
    .sat_hi  (s1_q.sat_hi),
    .sat_lo  (s1_q.sat_lo),
    .mag     (s2_mag)
  );

  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.zero = s1_q.zero;
    s2_d.nar  = s1_q.nar;
    s2_d.mag  = s2_mag;
  end

  // NaR outranks zero; negative values are the two's complement of the magnitude byte
  always_comb begin
    out_d = {1'b0, s2_q.mag};
    if (s2_q.nar) begin
      out_d = POSIT_NAR;
    end else if (s2_q.zero) begin
      out_d = POSIT_ZERO;
    end else if (s2_q.sign) begin
      out_d = (~{1'b0, s2_q.mag}) + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_posit <= POSIT_ZERO;
    end else begin
      if (s1_free) begin
        v1 <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_free) begin
        v2 <= v1;
        if (v1) s2_q <= s2_d;
      end
      if (s3_free) begin
        v3 <= v2;
        if (v2) out_posit <= out_d;
      end
    end
  end

endmodule

// File: tb/tb_posit_pack_8bit.sv
// Self-checking bench for posit_pack_8bit: directed table, randomized stream with back-pressure
// scored against a nearest-value posit model, and a mid-stream reset sequence.
module tb_posit_pack_8bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] in_uposit;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_posit;

  int errors = 0;
  int checks = 0;
  int occ    = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_req;
  logic       accepted;
  logic       rand_ready = 1'b0;

  typedef struct {
    logic        sign;
    logic [4:0]  exp;
    logic [12:0] frac;
    logic        zero;
    logic        nar;
    logic [7:0]  req;
  } vec_t;

  vec_t table_v[19];

  posit_pack_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_uposit (in_uposit),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value of positive posit pattern m (1..127) in units of 2^-27
  function automatic longint posit_value(input int m);
    int b6, n, r, fb, f;
    b6 = (m >> 6) & 1;
    n  = 0;
    for (int i = 6; i >= 0; i--) begin
      if (((m >> i) & 1) == b6) n++;
      else break;
    end
    r  = b6 ? n - 1 : -n;
    fb = (n >= 6) ? 0 : 6 - n;
    f  = m & ((1 << fb) - 1);
    return ((longint'(1) << fb) + longint'(f)) << (r + 27 - fb);
  endfunction

  // Nearest representable posit, ties to even pattern, clamped to minpos..maxpos
  function automatic logic [7:0] ref_posit(input logic s, input logic [4:0] e,
                                           input logic [12:0] f, input logic z, input logic n);
    longint v;
    longint mid;
    int m;
    logic [7:0] mag;
    if (n) return 8'h80;
    if (z) return 8'h00;
    v = (longint'(8192) + longint'(f)) << e;
    m = 1;
    while (m < 127) begin
      mid = posit_value(m) + posit_value(m + 1);
      if ((2 * v > mid) || ((2 * v == mid) && (m % 2 == 1))) m++;
      else break;
    end
    mag = 8'(m);
    return s ? 8'(-mag) : mag;
  endfunction

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
    end
  endtask

  // One clock: handshake bookkeeping before the edge, stall-hold check after it
  task automatic tick();
    logic       held;
    logic [7:0] held_val;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    #1;
    check_output("in_ready", {7'b0, in_ready}, {7'b0, !((occ == 3) && !out_ready)});
    held     = out_valid && !out_ready;
    held_val = out_posit;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got 0x%02h, required no word", out_posit);
      end else begin
        check_output("out_posit", out_posit, exp_q.pop_front());
      end
      occ--;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_req);
      accepted = 1'b1;
      occ++;
    end
    @(posedge clk);
    #1;
    if (held) begin
      check_output("hold_valid", {7'b0, out_valid}, 8'h01);
      check_output("hold_posit", out_posit, held_val);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [4:0] e, input logic [12:0] f,
                                input logic z, input logic n, input logic [7:0] req);
    in_valid  = 1'b1;
    in_uposit = {s, e, f};
    in_zero   = z;
    in_nar    = n;
    cur_req   = req;
    accepted  = 1'b0;
    for (int a = 0; a < 200 && !accepted; a++) tick();
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept, required accept within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    in_uposit = 19'($urandom);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int lat;
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic s, z, n;
    logic [4:0] e;
    logic [12:0] f;

    table_v[0]  = '{1'b0, 5'd14, 13'h0000, 1'b0, 1'b0, 8'h40};
    table_v[1]  = '{1'b0, 5'd14, 13'h1000, 1'b0, 1'b0, 8'h50};
    table_v[2]  = '{1'b1, 5'd14, 13'h0000, 1'b0, 1'b0, 8'hC0};
    table_v[3]  = '{1'b0, 5'd14, 13'h0080, 1'b0, 1'b0, 8'h40};
    table_v[4]  = '{1'b0, 5'd14, 13'h0081, 1'b0, 1'b0, 8'h41};
    table_v[5]  = '{1'b0, 5'd14, 13'h1F80, 1'b0, 1'b0, 8'h60};
    table_v[6]  = '{1'b0, 5'd20, 13'h0000, 1'b0, 1'b0, 8'h7F};
    table_v[7]  = '{1'b0, 5'd21, 13'h0000, 1'b0, 1'b0, 8'h7F};
    table_v[8]  = '{1'b0, 5'd8,  13'h0000, 1'b0, 1'b0, 8'h01};
    table_v[9]  = '{1'b0, 5'd7,  13'h0000, 1'b0, 1'b0, 8'h01};
    table_v[10] = '{1'b1, 5'd7,  13'h0000, 1'b0, 1'b0, 8'hFF};
    table_v[11] = '{1'b0, 5'd14, 13'h0A5A, 1'b1, 1'b0, 8'h00};
    table_v[12] = '{1'b0, 5'd14, 13'h0000, 1'b0, 1'b1, 8'h80};
    table_v[13] = '{1'b1, 5'd3,  13'h1234, 1'b1, 1'b1, 8'h80};
    table_v[14] = '{1'b0, 5'd13, 13'h0000, 1'b0, 1'b0, 8'h20};
    table_v[15] = '{1'b1, 5'd31, 13'h1FFF, 1'b0, 1'b0, 8'h81};
    table_v[16] = '{1'b0, 5'd8,  13'h1000, 1'b0, 1'b0, 8'h02};
    table_v[17] = '{1'b0, 5'd19, 13'h1000, 1'b0, 1'b0, 8'h7E};
    table_v[18] = '{1'b1, 5'd0,  13'h0000, 1'b1, 1'b0, 8'h00};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_uposit = '0;
    in_zero   = 1'b0;
    in_nar    = 1'b0;
    out_ready = 1'b1;
    #3;
    check_output("reset_out_valid", {7'b0, out_valid}, 8'h00);
    check_output("reset_out_posit", out_posit, 8'h00);
    check_output("reset_in_ready", {7'b0, in_ready}, 8'h01);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] latency check");
    apply_stimulus(table_v[0].sign, table_v[0].exp, table_v[0].frac,
                   table_v[0].zero, table_v[0].nar, table_v[0].req);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_output("latency", 8'(lat), 8'd3);
    drain();

    $display("[TB] directed table, back-to-back");
    for (int i = 0; i < 19; i++) begin
      apply_stimulus(table_v[i].sign, table_v[i].exp, table_v[i].frac,
                     table_v[i].zero, table_v[i].nar, table_v[i].req);
    end
    drain();

    $display("[TB] randomized stream with back-pressure");
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      s = 1'($urandom);
      e = ($urandom_range(0, 1) == 0) ? 5'($urandom) : 5'($urandom_range(6, 22));
      f = 13'($urandom);
      if ($urandom_range(0, 3) == 0) f = {5'($urandom), 8'h80};
      z = ($urandom_range(0, 15) == 0);
      n = ($urandom_range(0, 15) == 0);
      apply_stimulus(s, e, f, z, n, ref_posit(s, e, f, z, n));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("[TB] reset with words in flight");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 5'd15, 13'(i * 512), 1'b0, 1'b0, ref_posit(1'b0, 5'd15, 13'(i * 512), 1'b0, 1'b0));
    end
    in_valid = 1'b0;
    tick();
    check_output("full_in_ready", {7'b0, in_ready}, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset_out_valid", {7'b0, out_valid}, 8'h00);
    check_output("midreset_out_posit", out_posit, 8'h00);
    check_output("midreset_in_ready", {7'b0, in_ready}, 8'h01);
    exp_q.delete();
    occ = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_output("release_in_ready", {7'b0, in_ready}, 8'h01);
    @(posedge clk);
    #1;
    check_output("post_release_in_ready", {7'b0, in_ready}, 8'h01);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("no_stale_valid", {7'b0, out_valid}, 8'h00);
    end
    apply_stimulus(1'b1, 5'd14, 13'h1000, 1'b0, 1'b0, 8'hB0);
    apply_stimulus(1'b0, 5'd16, 13'h0000, 1'b0, 1'b0, 8'h70);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/posit_pack_8bit.md
# posit_pack_8bit

Packs an unpacked posit product (sign | biased exponent | 13-bit fraction, as emitted by the 8-bit multiplier) back into an 8-bit posit (es = 0) with round-to-nearest-even and saturation. Sits directly downstream of the multiplier and closes the unpack → compute → pack datapath. It is a 3-stage valid/ready pipeline, so it can absorb back-pressure from the register-file write port.

## Interface
- No parameters; widths are fixed by the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word present
- in_ready  out  1  block accepts the word this cycle
- in_uposit  in  19  [18] sign, [17:13] exponent (unsigned, bias 14), [12:0] fraction below implicit 1
- in_zero  in  1  value is exactly zero; overrides in_uposit
- in_nar  in  1  value is NaR; overrides in_zero and in_uposit
- out_valid  out  1  out_posit holds a result
- out_ready  in  1  downstream accepts the result
- out_posit  out  8  packed posit

## Operation
- Scale k = exponent − 14; valid input range 0..31, so k spans −14..17.
- For k in −6..6, the magnitude string is the regime followed by the fraction. The string is 7 bits: bit 7 is reserved for the sign.
  - k ≥ 0: regime is k+1 ones, then a 0. At k = 6 the regime has no terminator.
  - k < 0: regime is −k zeros, then a 1.
  - Fraction bits fill the remaining positions MSB-first.
- Rounding is RNE on the 7-bit magnitude.
  - Guard = first dropped bit; sticky = OR of all later dropped bits.
  - Increment when guard & (sticky | lsb).
- Saturation, with no rounding to zero and no rounding to NaR:
  - k > 6, or a rounded magnitude overflow, gives 0x7F.
  - k < −6 gives 0x01.
  - A magnitude that rounds to 0 is forced to 0x01.
- If sign = 1, out_posit is the two's complement of the magnitude byte.
- in_nar gives 0x80. Otherwise in_zero gives 0x00. Both flags bypass rounding but still travel through the pipeline.
- Pipeline stages:
  - S1: latch the input, compute k, the saturation flags and the regime length.
  - S2: shift the regime and fraction into position, then round and saturate.
  - S3: apply the sign and specials into the out_posit register.

## Timing
- Latency is 3 cycles from the accepting edge (in_valid & in_ready) to out_valid high, when not stalled.
- Throughput is one word per cycle while out_ready stays high.
- Each stage holds a valid bit. A stage advances when its successor is empty or is itself advancing. The S3 stage advances when out_ready is high.
- in_ready = !v1 | advance1. It is combinational from out_ready and the valid bits, with no combinational path from in_valid.
- out_posit and out_valid stay stable while out_valid & !out_ready. No word is dropped or duplicated under any stall pattern.
- Reset, including mid-stream: all stage valids go to 0, out_valid = 0, out_posit = 0x00, and in-flight words are discarded. in_ready reads 1 while rst_n is low and on the first edge after release.
- An accept and an emit in the same cycle on a full pipeline is legal and keeps the pipeline full.

## Structure
- Package posit8_pkg holds:
  - widths UPOSIT_W = 19, FRAC_W = 13, EXP_W = 5
  - EXP_BIAS = 14
  - constants POSIT_ZERO = 8'h00, POSIT_NAR = 8'h80, POSIT_MAXPOS = 8'h7F, POSIT_MINPOS = 8'h01
  - a packed struct for the 19-bit unpacked word
- One sub-module, posit8_regime_round: the combinational S2 shift, round and saturate. The enclosing module owns all the pipeline registers and the handshake.

## Test plan
- Basic values, out_ready held 1:
  - sign 0, exp 14, frac 0 → 0x40 after 3 cycles
  - frac 13'h1000 → 0x50
  - sign 1, exp 14, frac 0 → 0xC0
- Rounding at k = 0:
  - frac 13'h0080 (exact tie) → 0x40
  - frac 13'h0081 (tie plus sticky) → 0x41
  - frac 13'h1F80 (rounds up past the all-ones fraction) → 0x60
- Saturation:
  - exp 20 (k = 6) → 0x7F
  - exp 21 → 0x7F
  - exp 8 (k = −6) → 0x01
  - exp 7 → 0x01
  - exp 7 with sign 1 → 0xFF
- Specials:
  - in_zero → 0x00
  - in_nar → 0x80
  - in_zero & in_nar together → 0x80
- Back-pressure: stream 8 words with random out_ready. Every word is emitted once, in order. out_posit holds during stalls. in_ready drops only when all 3 stages are full and out_ready = 0.
- Reset with 3 words in flight: assert rst_n = 0 → out_valid = 0 and out_posit = 0x00 immediately. After release, no stale word ever appears.
